// File: rtl/sdram_refresh_ctrl.sv
// ---------------------------------------------------------------------------
// sdram_refresh_ctrl
//
// SDRAM power-up initialisation and periodic auto-refresh scheduler.
// After reset it waits INIT_WAIT cycles and then issues PRECHARGE ALL, two
// AUTO REFRESH commands and LOAD MODE, each spaced by the matching command
// recovery time. Once init is done, an interval timer adds one refresh to a
// debt counter every REFRESH_INTERVAL cycles. The block requests the shared
// command bus from the arbiter and issues AUTO REFRESH commands until the
// debt is paid off.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   bus_gnt    in   arbiter grant of the SDRAM command bus
//   bus_req    out  command bus request
//   cmd_valid  out  one-cycle command strobe
//   cmd        out  0 = PRECHARGE ALL, 1 = AUTO REFRESH, 2 = LOAD MODE
//   mode_out   out  MODE_VALUE during a LOAD MODE strobe, otherwise 0
//   init_done  out  init sequence complete (stays high until reset)
//   debt       out  number of refreshes owed
//   urgent     out  debt >= MAX_DEBT-1
//   overflow   out  sticky: a tick arrived while debt was saturated
// ---------------------------------------------------------------------------
module sdram_refresh_ctrl #(
    parameter int          INIT_WAIT        = 10000,
    parameter int          REFRESH_INTERVAL = 780,
    parameter int          T_RP             = 2,
    parameter int          T_RFC            = 7,
    parameter int          T_MRD            = 2,
    parameter int          MAX_DEBT         = 8,
    parameter int          DEBT_W           = 4,
    parameter logic [12:0] MODE_VALUE       = 13'h0020
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_gnt,
    output logic              bus_req,
    output logic              cmd_valid,
    output logic [1:0]        cmd,
    output logic [12:0]       mode_out,
    output logic              init_done,
    output logic [DEBT_W-1:0] debt,
    output logic              urgent,
    output logic              overflow
);

    // The shared timer covers both the power-up wait (counting up) and the
    // command recovery waits (counting down), so it is sized for the largest.
    localparam int WAIT_MAX  = (T_RFC > T_RP) ? ((T_RFC > T_MRD) ? T_RFC : T_MRD)
                                              : ((T_RP  > T_MRD) ? T_RP  : T_MRD);
    localparam int TIMER_MAX = (INIT_WAIT > WAIT_MAX) ? INIT_WAIT : WAIT_MAX;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int IV_W      = $clog2(REFRESH_INTERVAL + 1);

    localparam logic [1:0] CMD_PRECHARGE = 2'd0;
    localparam logic [1:0] CMD_REFRESH   = 2'd1;
    localparam logic [1:0] CMD_LOAD_MODE = 2'd2;

    typedef enum logic [3:0] {
        RESET_WAIT,
        PRECHARGE,
        WAIT_RP,
        REF1,
        WAIT_RFC1,
        REF2,
        WAIT_RFC2,
        LOAD_MODE,
        WAIT_MRD,
        IDLE,
        AUTO_REF,
        WAIT_AREF
    } state_t;

    state_t              state_q,     state_d;
    logic [TIMER_W-1:0]  timer_q,     timer_d;
    logic [IV_W-1:0]     interval_q,  interval_d;
    logic [DEBT_W-1:0]   debt_q,      debt_d;
    logic                overflow_q,  overflow_d;
    logic                init_done_q, init_done_d;
    logic                bus_req_q,   bus_req_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [1:0]          cmd_q,       cmd_d;
    logic [12:0]         mode_out_q,  mode_out_d;
    logic                urgent_q,    urgent_d;

    logic                tick;
    logic                refresh_start;

    // Next-state logic for the sequencer. Wait states load timer with
    // T_x-2 on entry and leave when it reaches zero, giving T_x-1 wait
    // cycles and therefore exactly T_x cycles between command strobes.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        init_done_d = init_done_q;

        case (state_q)
            RESET_WAIT: begin
                // Timer counts up from its cleared value; the transition
                // happens on the INIT_WAIT-th edge after reset release.
                if (timer_q == TIMER_W'(INIT_WAIT - 1)) begin
                    state_d = PRECHARGE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            PRECHARGE: begin
                state_d = WAIT_RP;
                timer_d = TIMER_W'(T_RP - 2);
            end
            WAIT_RP: begin
                if (timer_q == '0) state_d = REF1;
                else               timer_d = timer_q - TIMER_W'(1);
            end
            REF1: begin
                state_d = WAIT_RFC1;
                timer_d = TIMER_W'(T_RFC - 2);
            end
            WAIT_RFC1: begin
                if (timer_q == '0) state_d = REF2;
                else               timer_d = timer_q - TIMER_W'(1);
            end
            REF2: begin
                state_d = WAIT_RFC2;
                timer_d = TIMER_W'(T_RFC - 2);
            end
            WAIT_RFC2: begin
                if (timer_q == '0) state_d = LOAD_MODE;
                else               timer_d = timer_q - TIMER_W'(1);
            end
            LOAD_MODE: begin
                state_d = WAIT_MRD;
                timer_d = TIMER_W'(T_MRD - 2);
            end
            WAIT_MRD: begin
                if (timer_q == '0) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            IDLE: begin
                if ((debt_q != '0) && bus_gnt) state_d = AUTO_REF;
            end
            AUTO_REF: begin
                state_d = WAIT_AREF;
                timer_d = TIMER_W'(T_RFC - 2);
            end
            WAIT_AREF: begin
                // Grant is only looked at in the last wait cycle, so losing
                // it mid-refresh never cuts tRFC short.
                if (timer_q == '0) begin
                    if ((debt_q != '0) && bus_gnt) state_d = AUTO_REF;
                    else                           state_d = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = RESET_WAIT;
                timer_d = '0;
            end
        endcase
    end

    // Interval timer and refresh debt. The timer is armed when init
    // completes and free-runs afterwards. The debt drops on the edge that
    // enters AUTO_REF, so the strobe cycle already shows the paid-off value;
    // a tick landing on that same edge cancels the decrement.
    always_comb begin
        interval_d    = interval_q;
        debt_d        = debt_q;
        overflow_d    = overflow_q;
        tick          = 1'b0;
        refresh_start = (state_d == AUTO_REF);

        if (init_done_q) begin
            tick = (interval_q == '0);
            if (tick) interval_d = IV_W'(REFRESH_INTERVAL - 1);
            else      interval_d = interval_q - IV_W'(1);
        end else if (init_done_d) begin
            interval_d = IV_W'(REFRESH_INTERVAL - 1);
        end

        if (refresh_start && !tick) begin
            debt_d = debt_q - DEBT_W'(1);
        end else if (tick && !refresh_start) begin
            if (debt_q < DEBT_W'(MAX_DEBT)) debt_d     = debt_q + DEBT_W'(1);
            else                            overflow_d = 1'b1;
        end
    end

    // Output decode from the next state and next debt, so every output is a
    // flop that lines up with the state it describes.
    always_comb begin
        cmd_valid_d = 1'b0;
        cmd_d       = CMD_PRECHARGE;
        mode_out_d  = '0;

        case (state_d)
            PRECHARGE: begin
                cmd_valid_d = 1'b1;
                cmd_d       = CMD_PRECHARGE;
            end
            REF1, REF2, AUTO_REF: begin
                cmd_valid_d = 1'b1;
                cmd_d       = CMD_REFRESH;
            end
            LOAD_MODE: begin
                cmd_valid_d = 1'b1;
                cmd_d       = CMD_LOAD_MODE;
                mode_out_d  = MODE_VALUE;
            end
            default: begin
                cmd_valid_d = 1'b0;
            end
        endcase

        // Request stays up through tRFC so the arbiter cannot hand the bus
        // to the read/write sequencer in the middle of a refresh.
        bus_req_d = ((state_d == IDLE) && (debt_d != '0)) ||
                    (state_d == AUTO_REF) || (state_d == WAIT_AREF);
        urgent_d  = (debt_d >= DEBT_W'(MAX_DEBT - 1));
    end

    // All state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_WAIT;
            timer_q     <= '0;
            interval_q  <= '0;
            debt_q      <= '0;
            overflow_q  <= 1'b0;
            init_done_q <= 1'b0;
            bus_req_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_PRECHARGE;
            mode_out_q  <= '0;
            urgent_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            interval_q  <= interval_d;
            debt_q      <= debt_d;
            overflow_q  <= overflow_d;
            init_done_q <= init_done_d;
            bus_req_q   <= bus_req_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            mode_out_q  <= mode_out_d;
            urgent_q    <= urgent_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign mode_out  = mode_out_q;
    assign init_done = init_done_q;
    assign debt      = debt_q;
    assign urgent    = urgent_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sdram_refresh_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdram_refresh_ctrl
//
// Self-checking bench for sdram_refresh_ctrl. A reference model tracks the
// controller in terms of edge numbers: init strobes fall on fixed edges,
// ticks fall every REFRESH_INTERVAL edges after init completes, and a new
// refresh may start only when the previous one is at least T_RFC edges old,
// debt is owed and the grant is high. Every cycle all outputs are compared
// against that model, and directed checkpoints pin down the key milestones.
// ---------------------------------------------------------------------------
module tb_sdram_refresh_ctrl;

    localparam int IW   = 20;
    localparam int RI   = 50;
    localparam int TRP  = 2;
    localparam int TRFC = 4;
    localparam int TMRD = 2;
    localparam int MAXD = 4;
    localparam int DW   = 4;
    localparam logic [12:0] MODE = 13'h0020;

    // Edges (after reset release) on which the init strobes appear.
    localparam int E_PRE  = IW;
    localparam int E_REF1 = E_PRE + TRP;
    localparam int E_REF2 = E_REF1 + TRFC;
    localparam int E_LMR  = E_REF2 + TRFC;
    localparam int E_DONE = E_LMR + TMRD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bus_gnt = 1'b0;
    logic          bus_req;
    logic          cmd_valid;
    logic [1:0]    cmd;
    logic [12:0]   mode_out;
    logic          init_done;
    logic [DW-1:0] debt;
    logic          urgent;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int edgeCount;
    int lastRef;
    int mDebt;
    bit mOverflow;

    sdram_refresh_ctrl #(
        .INIT_WAIT        (IW),
        .REFRESH_INTERVAL (RI),
        .T_RP             (TRP),
        .T_RFC            (TRFC),
        .T_MRD            (TMRD),
        .MAX_DEBT         (MAXD),
        .DEBT_W           (DW),
        .MODE_VALUE       (MODE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_gnt   (bus_gnt),
        .bus_req   (bus_req),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .mode_out  (mode_out),
        .init_done (init_done),
        .debt      (debt),
        .urgent    (urgent),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        edgeCount = 0;
        lastRef   = -1000;
        mDebt     = 0;
        mOverflow = 1'b0;
    endtask

    // Advance the model by one rising edge, given the grant seen at it.
    task automatic modelEdge(input logic gnt);
        int e;
        bit tick;
        bit start;
        edgeCount++;
        e     = edgeCount;
        tick  = (e > E_DONE) && (((e - E_DONE) % RI) == 0);
        start = (e > E_DONE) && (e >= lastRef + TRFC) && (gnt === 1'b1) && (mDebt > 0);
        if (start) lastRef = e;
        if (start && !tick) begin
            mDebt--;
        end else if (tick && !start) begin
            if (mDebt < MAXD) mDebt++;
            else              mOverflow = 1'b1;
        end
    endtask

    function automatic bit inWait();
        return (edgeCount > lastRef) && (edgeCount < lastRef + TRFC);
    endfunction

    // Compare every output against the model for the current edge count.
    task automatic checkAll();
        int         e;
        bit         initStrobe;
        logic [1:0] initCmd;
        bit         busy;
        bit         done;
        e          = edgeCount;
        initStrobe = (e == E_PRE) || (e == E_REF1) || (e == E_REF2) || (e == E_LMR);
        initCmd    = (e == E_PRE) ? 2'd0 : ((e == E_LMR) ? 2'd2 : 2'd1);
        busy       = (e >= lastRef) && (e < lastRef + TRFC);
        done       = (e >= E_DONE);
        checkOutput("cmd_valid", 16'(cmd_valid), 16'(initStrobe || (e == lastRef)));
        if (initStrobe)        checkOutput("cmd", 16'(cmd), 16'(initCmd));
        else if (e == lastRef) checkOutput("cmd", 16'(cmd), 16'd1);
        checkOutput("mode_out", 16'(mode_out), (e == E_LMR) ? 16'(MODE) : 16'd0);
        checkOutput("init_done", 16'(init_done), 16'(done));
        checkOutput("bus_req", 16'(bus_req), 16'(busy || (done && (mDebt > 0))));
        checkOutput("debt", 16'(debt), 16'(mDebt));
        checkOutput("urgent", 16'(urgent), 16'(mDebt >= MAXD - 1));
        checkOutput("overflow", 16'(overflow), 16'(mOverflow));
    endtask

    // mode: 0 = grant low, 1 = grant high, 2 = random grant. Called at a
    // falling edge; returns at a falling edge after n rising edges.
    task automatic applyStimulus(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            logic g;
            g = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
            bus_gnt = g;
            @(posedge clk);
            modelEdge(g);
            @(negedge clk);
            checkAll();
        end
    endtask

    task automatic runTo(input int mode, input int targetEdge);
        applyStimulus(mode, targetEdge - edgeCount);
    endtask

    // Assert reset without waiting for a clock edge so the asynchronous
    // clear is observed before any edge occurs.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_outputs",
                    16'({cmd_valid, cmd, init_done, bus_req, urgent, overflow, debt}), 16'd0);
        checkOutput("rst_mode", 16'(mode_out), 16'd0);
        checkAll();
        repeat (2) @(negedge clk);
        checkAll();
        rst_n = 1'b1;
    endtask

    task automatic runInitChecks();
        applyStimulus(2, E_PRE);
        checkOutput("init_precharge", 16'({cmd_valid, cmd}), 16'(3'b100));
        applyStimulus(2, TRP);
        checkOutput("init_ref1", 16'({cmd_valid, cmd}), 16'(3'b101));
        applyStimulus(2, TRFC);
        checkOutput("init_ref2", 16'({cmd_valid, cmd}), 16'(3'b101));
        applyStimulus(2, TRFC);
        checkOutput("init_load_mode", 16'({cmd_valid, cmd}), 16'(3'b110));
        checkOutput("init_mode_word", 16'(mode_out), 16'h0020);
        applyStimulus(2, TMRD);
        checkOutput("init_done_high", 16'(init_done), 16'd1);
        checkOutput("init_no_req", 16'(bus_req), 16'd0);
    endtask

    initial begin
        $display("[TB] start");
        doReset();
        runInitChecks();

        // Single refresh with grant tied high.
        runTo(1, E_DONE + RI);
        checkOutput("first_tick_debt", 16'(debt), 16'd1);
        checkOutput("first_tick_req", 16'(bus_req), 16'd1);
        applyStimulus(1, 1);
        checkOutput("single_strobe", 16'({cmd_valid, cmd}), 16'(3'b101));
        checkOutput("single_debt", 16'(debt), 16'd0);
        applyStimulus(1, TRFC - 1);
        checkOutput("single_req_held", 16'(bus_req), 16'd1);
        applyStimulus(1, 1);
        checkOutput("single_req_fall", 16'(bus_req), 16'd0);

        // Debt accumulation and saturation with grant withheld.
        for (int k = 1; k <= 6; k++) begin
            runTo(0, E_DONE + (k + 1) * RI);
            checkOutput("sat_debt", 16'(debt), 16'((k < MAXD) ? k : MAXD));
            checkOutput("sat_urgent", 16'(urgent), 16'(k >= MAXD - 1));
            checkOutput("sat_overflow", 16'(overflow), 16'(k > MAXD));
        end

        // Back-to-back drain from saturation.
        for (int k = 0; k < MAXD; k++) begin
            applyStimulus(1, (k == 0) ? 1 : TRFC);
            checkOutput("drain_strobe", 16'({cmd_valid, cmd}), 16'(3'b101));
            checkOutput("drain_debt", 16'(debt), 16'(MAXD - 1 - k));
        end
        applyStimulus(1, TRFC);
        checkOutput("drain_end_debt", 16'(debt), 16'd0);
        checkOutput("drain_end_req", 16'(bus_req), 16'd0);
        checkOutput("drain_overflow_kept", 16'(overflow), 16'd1);

        // Grant withdrawn during WAIT_AREF with debt still owed.
        runTo(0, E_DONE + 9 * RI);
        checkOutput("wd_debt", 16'(debt), 16'd2);
        applyStimulus(1, 1);
        checkOutput("wd_strobe", 16'({cmd_valid, cmd}), 16'(3'b101));
        applyStimulus(0, TRFC);
        checkOutput("wd_idle_req", 16'(bus_req), 16'd1);
        checkOutput("wd_idle_debt", 16'(debt), 16'd1);
        checkOutput("wd_no_strobe", 16'(cmd_valid), 16'd0);

        // Tick on the same edge that starts a refresh.
        runTo(0, E_DONE + 10 * RI - 1);
        applyStimulus(1, 1);
        checkOutput("coincide_strobe", 16'({cmd_valid, cmd}), 16'(3'b101));
        checkOutput("coincide_debt", 16'(debt), 16'd1);
        applyStimulus(1, TRFC);
        checkOutput("coincide_next_debt", 16'(debt), 16'd0);

        // Randomised grant pattern, checked cycle by cycle against the model.
        applyStimulus(2, 400);

        // Reset in the middle of a refresh wait, bounded search for it.
        for (int i = 0; i < 4 * RI && !inWait(); i++) applyStimulus(1, 1);
        checkOutput("reach_wait_aref", 16'(inWait()), 16'd1);
        checkOutput("reach_wait_req", 16'(bus_req), 16'd1);
        doReset();
        runInitChecks();
        applyStimulus(2, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_refresh_ctrl.md
# sdram_refresh_ctrl

SDRAM power-up initialisation and periodic auto-refresh scheduler. After reset it issues the JEDEC init sequence: wait, PRECHARGE ALL, two AUTO REFRESH, LOAD MODE. It then accrues refresh debt on a fixed interval and requests the shared SDRAM command bus from the arbiter to pay that debt off. It sits beside the read/write sequencer and feeds the SDRAM command mux.

## Interface
- INIT_WAIT, 10000: power-up wait in cycles (100 us at 100 MHz).
- REFRESH_INTERVAL, 780: cycles between refresh ticks (7.8 us).
- T_RP, 2: command-to-command cycles after PRECHARGE.
- T_RFC, 7: command-to-command cycles after AUTO REFRESH.
- T_MRD, 2: command-to-command cycles after LOAD MODE.
- MAX_DEBT, 8: refresh debt saturation value.
- DEBT_W, 4: debt counter width; MAX_DEBT ≤ 2^DEBT_W−1.
- MODE_VALUE, 13'h0020: mode register word (CAS 2, burst 1, sequential).
- All T_* parameters ≥ 2; INIT_WAIT and REFRESH_INTERVAL ≥ 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- BUS_GNT  in  1  arbiter grant of the SDRAM command bus.
- BUS_REQ  out  1  bus request.
- CMD_VALID  out  1  one-cycle command strobe.
- CMD  out  2  0 = PRECHARGE ALL, 1 = AUTO REFRESH, 2 = LOAD MODE.
- MODE_OUT  out  13  equals MODE_VALUE during a LOAD MODE strobe, otherwise 0.
- INIT_DONE  out  1  init sequence complete; stays high.
- DEBT  out  DEBT_W  refreshes owed.
- URGENT  out  1  DEBT ≥ MAX_DEBT−1.
- OVERFLOW  out  1  sticky; a tick arrived while DEBT = MAX_DEBT.

## Operation
- States: RESET_WAIT, PRECHARGE, WAIT_RP, REF1, WAIT_RFC1, REF2, WAIT_RFC2, LOAD_MODE, WAIT_MRD, IDLE, AUTO_REF, WAIT_AREF.
- Command states are PRECHARGE, REF1, REF2, LOAD_MODE and AUTO_REF. Each lasts exactly one cycle with CMD_VALID = 1 and the matching CMD. All outputs decode from registered state and counters only.
- The next command is issued no earlier than T_x cycles after the previous command cycle. Each wait state therefore lasts T_x−1 cycles, timed by an internal down-counter that is loaded on entry.
- RESET_WAIT lasts INIT_WAIT cycles. Init ignores BUS_GNT and does not assert BUS_REQ; the arbiter keeps the bus idle until INIT_DONE.
- WAIT_MRD exits to IDLE and sets INIT_DONE.
- Interval timer:
  - Runs only while INIT_DONE = 1.
  - Loads REFRESH_INTERVAL−1 and counts down.
  - At 0 it produces a one-cycle tick and reloads.
- Tick: if DEBT < MAX_DEBT then DEBT+1; otherwise DEBT holds and OVERFLOW is set.
- BUS_REQ = (IDLE and DEBT > 0) or state ∈ {AUTO_REF, WAIT_AREF}. The request is held through tRFC so the bus is not handed over mid-refresh.
- IDLE with DEBT > 0 and BUS_GNT = 1 goes to AUTO_REF in the next cycle. DEBT decrements in the AUTO_REF cycle.
- At the last WAIT_AREF cycle:
  - DEBT > 0 and BUS_GNT = 1: go to AUTO_REF (back-to-back refreshes).
  - Otherwise: go to IDLE.
- A tick and an AUTO_REF decrement in the same cycle leave DEBT unchanged. Saturation is checked against the pre-decrement value only if no decrement occurs in that cycle.
- BUS_GNT dropping during WAIT_AREF does not abort the wait; the block finishes tRFC and then returns to IDLE.
- OVERFLOW is cleared only by reset.

## Timing
- Reset values: state RESET_WAIT; CMD_VALID, CMD, MODE_OUT, INIT_DONE, BUS_REQ, DEBT, URGENT and OVERFLOW all 0; timers cleared.
- Reset asserted at any time, including mid-refresh or mid-init:
  - All outputs go to their reset values immediately (asynchronous).
  - Init restarts from RESET_WAIT after RST_N rises.
- Edge numbering: edge 1 is the first rising CLK edge with RST_N high.
- Init milestones:
  - PRECHARGE strobe after edge INIT_WAIT.
  - REF1 after edge INIT_WAIT+T_RP.
  - REF2 after a further T_RFC edges.
  - LOAD_MODE after a further T_RFC edges.
  - INIT_DONE after a further T_MRD edges.
- First tick: REFRESH_INTERVAL edges after INIT_DONE rises. DEBT becomes 1 and BUS_REQ rises in the same cycle.
- Grant-to-command latency: 1 cycle. Refresh-to-refresh spacing under continuous grant: exactly T_RFC cycles.

## Test plan
Use parameters INIT_WAIT=20, REFRESH_INTERVAL=50, T_RP=2, T_RFC=4, T_MRD=2, MAX_DEBT=4.

- Init sequence:
  - Release reset, then expect single-cycle strobes after edges 20 (CMD=0), 22 (CMD=1), 26 (CMD=1) and 30 (CMD=2, MODE_OUT=0x020).
  - INIT_DONE is high after edge 32.
  - BUS_REQ stays 0 throughout init.
- Single refresh:
  - Tie BUS_GNT=1. After edge 82, DEBT=1 and BUS_REQ=1.
  - The AUTO_REF strobe follows one cycle later and DEBT returns to 0.
  - BUS_REQ falls 4 cycles after the strobe.
- Debt accumulation and saturation:
  - Hold BUS_GNT=0 for 6 intervals.
  - DEBT goes 1, 2, 3, 4 and then holds at 4.
  - URGENT=1 once DEBT ≥ 3; OVERFLOW=1 at the fifth tick.
- Back-to-back drain:
  - From DEBT=4, assert BUS_GNT=1.
  - Expect 4 AUTO_REF strobes exactly 4 cycles apart, then DEBT=0 and BUS_REQ=0.
  - OVERFLOW remains 1.
- Grant withdrawn and simultaneous events:
  - Drop BUS_GNT in WAIT_AREF: the block finishes tRFC, goes to IDLE and holds BUS_REQ while DEBT > 0.
  - A tick coinciding with an AUTO_REF cycle leaves DEBT unchanged.
- Reset mid-refresh: assert RST_N=0 during WAIT_AREF. All outputs and DEBT clear immediately, and the init sequence repeats with the first-scenario timing.
